// File: rtl/fpu_pkg.sv
// Shared definitions for the FP adder sharing logic.
//   FP32_W      : single-precision word width
//   TAG_IDW     : id field width of an in-flight tag (wide enough for 8 requesters)
//   FP_ONE      : 1.0 in IEEE-754 single precision
//   req_state_t : per-requester state (ST_IDLE, ST_BUSY, ST_DONE)
//   tag_t       : in-flight tag {vld, id}
package fpu_pkg;

  localparam int FP32_W  = 32;
  localparam int TAG_IDW = 3;

  localparam logic [FP32_W-1:0] FP_ONE = 32'h3F80_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } req_state_t;

  typedef struct packed {
    logic               vld;
    logic [TAG_IDW-1:0] id;
  } tag_t;

endpackage

// File: rtl/fadd_arbiter_rr.sv
// Round-robin priority pick: grants the first eligible index strictly after
// ptr, wrapping modulo NREQ. Purely combinational.
// Ports:
//   eligible : per-requester eligibility
//   ptr      : index granted most recently
//   gnt      : one-hot grant (all zero when nothing is eligible)
//   gnt_idx  : binary index of the grant (0 when none)
//   gnt_any  : a grant was made
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] eligible,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx,
  output logic            gnt_any
);

  // Scan from the farthest candidate to the nearest so the last hit, which
  // wins, is the nearest eligible index after ptr.
  always_comb begin : pick
    int idx;
    idx     = 0;
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int off = NREQ; off >= 1; off--) begin
      idx = (int'(ptr) + off) % NREQ;
      if (eligible[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        gnt_idx  = IDW'(idx);
        gnt_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fadd_arbiter.sv
// Shares one fixed-latency pipelined FP32 adder among NREQ requesters.
// One operation is issued per cycle in round-robin order; a LAT-deep tag
// pipeline follows each operation and steers its result into a one-entry
// per-requester response buffer (valid/ready).
// Optional feature: define FADD_ARBITER_PERF_EN to add saturating counters
// perf_issue (grants) and perf_conflict (cycles with >=2 waiting requesters).
// Ports:
//   clk, reset           : clock, synchronous active-low reset
//   req_valid/op1/op2    : per-requester requests, operands packed 32 bits each
//   req_ready            : one-hot combinational grant
//   resp_valid/data/uflow: per-requester result buffer, resp_ready consumes
//   fadd_op1/op2         : registered operands to the adder
//   fadd_result/valid    : adder result, valid=0 flags underflow
module fadd_arbiter
  import fpu_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int LAT  = 3,
  parameter int IDW  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*FP32_W-1:0]   req_op1,
  input  logic [NREQ*FP32_W-1:0]   req_op2,
  output logic [NREQ-1:0]          req_ready,
  output logic [NREQ-1:0]          resp_valid,
  output logic [NREQ*FP32_W-1:0]   resp_data,
  output logic [NREQ-1:0]          resp_uflow,
  input  logic [NREQ-1:0]          resp_ready,
  output logic [FP32_W-1:0]        fadd_op1,
  output logic [FP32_W-1:0]        fadd_op2,
  input  logic [FP32_W-1:0]        fadd_result,
  input  logic                     fadd_valid
`ifdef FADD_ARBITER_PERF_EN
  ,
  output logic [31:0]              perf_issue,
  output logic [31:0]              perf_conflict
`endif
);

  req_state_t state     [NREQ];
  req_state_t state_nxt [NREQ];

  tag_t tag_p [LAT];
  tag_t tag_exit;

  logic [IDW-1:0]    rr_ptr;
  logic [NREQ-1:0]   eligible;
  logic [NREQ-1:0]   gnt;
  logic [IDW-1:0]    gnt_idx;
  logic              gnt_any;
  logic [NREQ-1:0]   exit_hit;
  logic [FP32_W-1:0] sel_op1;
  logic [FP32_W-1:0] sel_op2;

  assign tag_exit = tag_p[LAT-1];

  // A DONE requester consumed this cycle is still not IDLE, so it only
  // becomes eligible on the following cycle.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      eligible[i]   = (state[i] == ST_IDLE) && req_valid[i];
      resp_valid[i] = (state[i] == ST_DONE);
      exit_hit[i]   = tag_exit.vld && (tag_exit.id == TAG_IDW'(i));
    end
  end

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .eligible (eligible),
    .ptr      (rr_ptr),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .gnt_any  (gnt_any)
  );

  assign req_ready = gnt;

  always_comb begin
    sel_op1 = '0;
    sel_op2 = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_op1 = req_op1[i*FP32_W +: FP32_W];
        sel_op2 = req_op2[i*FP32_W +: FP32_W];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      state_nxt[i] = state[i];
      case (state[i])
        ST_IDLE: if (gnt[i])        state_nxt[i] = ST_BUSY;
        ST_BUSY: if (exit_hit[i])   state_nxt[i] = ST_DONE;
        ST_DONE: if (resp_ready[i]) state_nxt[i] = ST_IDLE;
        default:                    state_nxt[i] = ST_IDLE;
      endcase
    end
  end

  // Issue stage: tag entry 0 and the adder operands load at the grant edge;
  // tag entry LAT-1 lines up with the adder result sampled LAT edges later.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREQ; i++) state[i] <= ST_IDLE;
      for (int k = 0; k < LAT; k++)  tag_p[k] <= '0;
      rr_ptr <= IDW'(NREQ - 1);
    end else begin
      for (int i = 0; i < NREQ; i++) state[i] <= state_nxt[i];
      tag_p[0] <= tag_t'{vld: gnt_any, id: TAG_IDW'(gnt_idx)};
      for (int k = 1; k < LAT; k++) tag_p[k] <= tag_p[k-1];
      if (gnt_any) rr_ptr <= gnt_idx;
    end
  end

  // Operand registers hold when idle; the adder output is then ignored.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fadd_op1 <= '0;
      fadd_op2 <= '0;
    end else if (gnt_any) begin
      fadd_op1 <= sel_op1;
      fadd_op2 <= sel_op2;
    end
  end

  // Result capture stage
  always_ff @(posedge clk) begin
    if (!reset) begin
      resp_data  <= '0;
      resp_uflow <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (exit_hit[i]) begin
          resp_data[i*FP32_W +: FP32_W] <= fadd_result;
          resp_uflow[i]                 <= ~fadd_valid;
        end
      end
    end
  end

`ifdef FADD_ARBITER_PERF_EN
  logic conflict;
  assign conflict = $countones(req_valid & ~gnt) >= 2;

  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_issue    <= '0;
      perf_conflict <= '0;
    end else begin
      if (gnt_any && (perf_issue != '1))     perf_issue    <= perf_issue + 32'd1;
      if (conflict && (perf_conflict != '1)) perf_conflict <= perf_conflict + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fadd_arbiter.sv
// Bench for fadd_arbiter: a pipelined adder stub, a request-level model
// scoring every cycle, and directed scenarios with literal expectations.
module tb_fadd_arbiter;
  import fpu_pkg::*;

  localparam int NREQ = 4;
  localparam int LAT  = 3;
  localparam int IDW  = 2;
  localparam logic [31:0] UF_MAGIC = 32'h0080_0000;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*32-1:0]   req_op1, req_op2;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      resp_valid;
  logic [NREQ*32-1:0]   resp_data;
  logic [NREQ-1:0]      resp_uflow;
  logic [NREQ-1:0]      resp_ready;
  logic [31:0]          fadd_op1, fadd_op2, fadd_result;
  logic                 fadd_valid;
`ifdef FADD_ARBITER_PERF_EN
  logic [31:0]          perf_issue, perf_conflict;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fadd_arbiter #(.NREQ(NREQ), .LAT(LAT), .IDW(IDW)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_op1     (req_op1),
    .req_op2     (req_op2),
    .req_ready   (req_ready),
    .resp_valid  (resp_valid),
    .resp_data   (resp_data),
    .resp_uflow  (resp_uflow),
    .resp_ready  (resp_ready),
    .fadd_op1    (fadd_op1),
    .fadd_op2    (fadd_op2),
    .fadd_result (fadd_result),
    .fadd_valid  (fadd_valid)
`ifdef FADD_ARBITER_PERF_EN
    ,
    .perf_issue    (perf_issue),
    .perf_conflict (perf_conflict)
`endif
  );

  // FP32 add through double precision; exact for the operands used here.
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'd0) return 0.0;
    d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) + f2r(b));
  endfunction

  // Adder stub: LAT edges from operand register to sampled result; it flags
  // underflow whenever operand A equals UF_MAGIC.
  logic [31:0] add_pipe [2];
  logic        uf_pipe  [2];
  always @(posedge clk) begin
    add_pipe[0] <= fp_add(fadd_op1, fadd_op2);
    uf_pipe[0]  <= (fadd_op1 == UF_MAGIC);
    add_pipe[1] <= add_pipe[0];
    uf_pipe[1]  <= uf_pipe[0];
  end
  assign fadd_result = add_pipe[1];
  assign fadd_valid  = ~uf_pipe[1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Request-level model: a requester is waiting for a result, holding one,
  // or free; a result appears LAT+1 cycles after its grant cycle.
  bit              m_on = 1'b0;
  bit              m_pend [NREQ];
  bit              m_hold [NREQ];
  int              m_due  [NREQ];
  logic [31:0]     m_data [NREQ];
  bit              m_uf   [NREQ];
  int              m_last;
  int              m_issue, m_conf;
  logic [NREQ-1:0] exp_rdy;
  int              j;

  always @(negedge clk) begin
    exp_rdy = '0;
    if (m_on) begin
      for (int i = 0; i < NREQ; i++)
        if (m_pend[i] && m_due[i] == cyc) begin
          m_pend[i] = 1'b0;
          m_hold[i] = 1'b1;
        end
      for (int off = 1; off <= NREQ; off++) begin
        j = (m_last + off) % NREQ;
        if (exp_rdy == '0 && req_valid[j] && !m_pend[j] && !m_hold[j]) exp_rdy[j] = 1'b1;
      end
      chk("model_req_ready", 32'(req_ready), 32'(exp_rdy));
      for (int i = 0; i < NREQ; i++) begin
        chk("model_resp_valid", 32'(resp_valid[i]), 32'(m_hold[i]));
        if (m_hold[i]) begin
          chk("model_resp_data", resp_data[i*32 +: 32], m_data[i]);
          chk("model_resp_uflow", 32'(resp_uflow[i]), 32'(m_uf[i]));
        end
      end
    end
    if (!reset) begin
      for (int i = 0; i < NREQ; i++) begin
        m_pend[i] = 1'b0;
        m_hold[i] = 1'b0;
      end
      m_last  = NREQ - 1;
      m_issue = 0;
      m_conf  = 0;
      m_on    = 1'b1;
    end else if (m_on) begin
      if (exp_rdy != '0) m_issue++;
      if ($countones(req_valid & ~exp_rdy) >= 2) m_conf++;
      for (int i = 0; i < NREQ; i++) begin
        if (m_hold[i] && resp_ready[i]) m_hold[i] = 1'b0;
        if (exp_rdy[i]) begin
          m_pend[i] = 1'b1;
          m_due[i]  = cyc + LAT + 1;
          m_data[i] = fp_add(req_op1[i*32 +: 32], req_op2[i*32 +: 32]);
          m_uf[i]   = (req_op1[i*32 +: 32] == UF_MAGIC);
          m_last    = i;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    req_op1[i*32 +: 32] = a;
    req_op2[i*32 +: 32] = b;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic set_rr_ops();
    set_op(0, FP_ONE,        32'h4000_0000);  // 1+2    = 3
    set_op(1, 32'h4000_0000, 32'h4000_0000);  // 2+2    = 4
    set_op(2, 32'h3F00_0000, 32'h3F00_0000);  // .5+.5  = 1
    set_op(3, 32'h3FC0_0000, 32'h3E80_0000);  // 1.5+.25 = 1.75
  endtask

  // Waits for resp_valid[i]; returns cycles elapsed since the grant cycle.
  task automatic wait_resp(input int i, output int n);
    n = 1;
    while (!resp_valid[i] && n < 12) begin
      tick();
      #1;
      n++;
    end
  endtask

  logic [31:0] rr_exp [NREQ];
  int n;

  initial begin
    rr_exp[0] = 32'h4040_0000;
    rr_exp[1] = 32'h4080_0000;
    rr_exp[2] = 32'h3F80_0000;
    rr_exp[3] = 32'h3FE0_0000;
    reset      = 1'b0;
    req_valid  = '0;
    req_op1    = '0;
    req_op2    = '0;
    resp_ready = '1;
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_req_ready",  32'(req_ready),  32'h0);
    chk("rst_resp_uflow", 32'(resp_uflow), 32'h0);
    chk("rst_fadd_op1",   fadd_op1, 32'h0);
    chk("rst_fadd_op2",   fadd_op2, 32'h0);

    // Single op: 1.0 + 1.0
    tick();
    set_op(0, FP_ONE, FP_ONE);
    req_valid = 4'b0001;
    #1;
    chk("single_grant", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    #1;
    chk("single_fadd_op1", fadd_op1, FP_ONE);
    wait_resp(0, n);
    chk("single_latency", 32'(n), 32'(LAT + 1));
    chk("single_data",  resp_data[31:0], 32'h4000_0000);
    chk("single_uflow", 32'(resp_uflow[0]), 32'h0);
    repeat (4) tick();

    // Round-robin with all four requesting
    pulse_reset();
    set_rr_ops();
    req_valid = 4'b1111;
    for (int k = 0; k < NREQ; k++) begin
      #1;
      chk("rr_grant", 32'(req_ready), 32'(1 << k));
      tick();
      req_valid[k] = 1'b0;
    end
    for (int k = 0; k < NREQ; k++) begin
      #1;
      chk("rr_resp_valid", 32'(resp_valid), 32'(1 << k));
      chk("rr_resp_data",  resp_data[k*32 +: 32], rr_exp[k]);
      tick();
    end
    repeat (4) tick();

    // Backpressure on requester 1
    pulse_reset();
    set_rr_ops();
    resp_ready = 4'b1101;
    req_valid  = 4'b0011;
    #1; chk("bp_c0_grant", 32'(req_ready), 32'h1);
    tick(); #1; chk("bp_c1_grant", 32'(req_ready), 32'h2);
    tick(); tick(); tick(); #1;
    chk("bp_c4_grant", 32'(req_ready), 32'h0);
    chk("bp_c4_resp",  32'(resp_valid), 32'h1);
    tick(); #1;
    chk("bp_c5_grant", 32'(req_ready), 32'h1);
    chk("bp_c5_resp",  32'(resp_valid), 32'h2);
    chk("bp_c5_data",  resp_data[63:32], 32'h4080_0000);
    tick(); #1;
    chk("bp_c6_grant", 32'(req_ready), 32'h0);
    tick();
    resp_ready = 4'b1111;
    #1;
    chk("bp_c7_grant", 32'(req_ready), 32'h0);
    chk("bp_c7_hold",  32'(resp_valid[1]), 32'h1);
    tick(); #1;
    chk("bp_c8_grant", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    repeat (6) tick();

    // Underflow flagged by the adder for requester 2
    set_op(2, UF_MAGIC, UF_MAGIC);
    req_valid = 4'b0100;
    #1; chk("uf_grant", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    #1;
    wait_resp(2, n);
    chk("uf_latency", 32'(n), 32'(LAT + 1));
    chk("uf_flag", 32'(resp_uflow[2]), 32'h1);
    chk("uf_data", resp_data[95:64], 32'h0100_0000);
    repeat (4) tick();

    // Reset one cycle after three grants
    pulse_reset();
    set_rr_ops();
    req_valid = 4'b1111;
    tick(); req_valid[0] = 1'b0;
    tick(); req_valid[1] = 1'b0;
    tick();
    req_valid = '0;
    reset     = 1'b0;
    tick();
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("rst_flight_no_resp", 32'(resp_valid), 32'h0);
      tick();
    end
    set_op(0, 32'h4000_0000, FP_ONE);
    req_valid = 4'b0001;
    #1; chk("post_rst_grant", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    #1;
    wait_resp(0, n);
    chk("post_rst_latency", 32'(n), 32'(LAT + 1));
    chk("post_rst_data", resp_data[31:0], 32'h4040_0000);
    repeat (4) tick();

`ifdef FADD_ARBITER_PERF_EN
    chk("perf_issue",    perf_issue,    32'(m_issue));
    chk("perf_conflict", perf_conflict, 32'(m_conf));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fadd_arbiter.md
Name: fadd_arbiter

Overview:
- Shares one pipelined single-precision adder (fixed latency, no stall input) among NREQ requesters.
- Round-robin issue of at most one operation per cycle; an in-flight ID pipeline tags each operation.
- Each result is routed back into a per-requester one-entry result buffer with a valid/ready response handshake.
- Sits between the core-side FP issue ports and the adder instance; the adder itself is unchanged.

Parameters:
- NREQ, 4, number of requesters (2..8).
- LAT, 3, cycles from the edge that registers fadd_op1/op2 to the edge at which fadd_result/fadd_valid are sampled (>=1).
- IDW, 2, requester ID width, clog2(NREQ).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-low
- req_valid  input  NREQ  per-requester operation request
- req_op1  input  NREQ*32  operand A, requester i in bits [32i+31:32i]
- req_op2  input  NREQ*32  operand B, same packing
- req_ready  output  NREQ  one-hot grant, combinational
- resp_valid  output  NREQ  result held for requester i
- resp_data  output  NREQ*32  result, same packing
- resp_uflow  output  NREQ  1 = adder flagged underflow (its valid output was low)
- resp_ready  input  NREQ  requester consumes result
- fadd_op1  output  32  registered operand to adder
- fadd_op2  output  32  registered operand to adder
- fadd_result  input  32  adder result
- fadd_valid  input  1  adder validity flag (0 = underflow)

Behaviour:
- Reset (reset==0 at posedge): every per-requester state is IDLE; resp_valid=0; resp_data=0; resp_uflow=0; fadd_op1/op2=0; rr_ptr=NREQ-1; all in-flight tags cleared. Any in-flight operation is discarded, and its result is never delivered.
- Per-requester FSM:
  - IDLE -> BUSY on grant.
  - BUSY -> DONE when its tag exits the pipeline.
  - DONE -> IDLE when resp_valid & resp_ready.
  - Eligible for grant only in IDLE with req_valid=1. A DONE requester that is consumed this cycle becomes eligible next cycle, not the same cycle.
- Arbitration: grant the first eligible index strictly after rr_ptr, wrapping modulo NREQ. req_ready is one-hot or zero and depends only on current state and req_valid. On a grant, rr_ptr <= granted index; with no grant, rr_ptr holds.
- Issue: on a grant, fadd_op1/op2 <= the granted operands at the same edge. With no grant, the operand registers hold their value; the adder computes garbage, and its result is ignored because the tag valid is 0.
- Tag pipeline: LAT-deep shift register of {vld, id}, entry 0 loaded at the grant edge with {1, granted index}. When entry LAT-1 has vld=1, at that edge:
  - resp_data[id] <= fadd_result
  - resp_uflow[id] <= ~fadd_valid
  - state[id] <= DONE
- Latency: result is visible on resp_valid exactly LAT+1 cycles after the req_valid&req_ready cycle.
- Throughput: one operation per cycle total; at most one outstanding operation per requester, so no buffer overflow is possible.
- Simultaneous events:
  - A tag exiting for requester i and a grant for requester j≠i at the same edge are independent.
  - A tag exit never targets a DONE requester (guaranteed by the FSM). Verification asserts this.
- resp_data/resp_uflow hold stable while resp_valid=1.

Optional Feature:
- Macro FADD_ARBITER_PERF_EN.
- Defined: adds outputs perf_issue (32 bits, total grants) and perf_conflict (32 bits, cycles with ≥2 requesters having req_valid=1 while not IDLE or losing arbitration). Both counters reset to 0, saturate at 0xFFFFFFFF, and are cleared only by reset.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package fpu_pkg:
  - FP32_W=32
  - localparam enum for requester state (ST_IDLE, ST_BUSY, ST_DONE)
  - typedef tag_t {logic vld; logic [IDW-1:0] id;}
  - Constant FP_ONE=32'h3F800000 for benches.
- One natural sub-module, rr_arbiter (NREQ-wide round-robin priority pick with pointer input, combinational one-hot out). The tag pipeline and FSMs stay in the top.

Test Plan:
- Single op: req 0 issues op1=0x3F800000, op2=0x3F800000 -> req_ready[0]=1 that cycle; resp_valid[0]=1 after LAT+1 cycles with resp_data[0]=0x40000000, resp_uflow[0]=0.
- Round-robin: all four req_valid held with distinct operands -> grants in order 0,1,2,3 on consecutive cycles; results return in the same order, each LAT+1 after its grant.
- Backpressure: requester 1 holds resp_ready=0 and keeps req_valid=1 -> no second grant to 1 while DONE; other requesters are still granted every cycle; req_ready[1] rises the cycle after resp_ready[1]=1.
- Underflow tag: the adder model returns fadd_valid=0 for requester 2's op -> resp_uflow[2]=1 with the data captured.
- Reset mid-flight: assert reset one cycle after three grants -> all resp_valid stay 0 afterwards; a first post-reset request is granted to index 0 and returns correct data.
- Perf (FADD_ARBITER_PERF_EN): 10 grants with 4 contention cycles -> perf_issue=10, perf_conflict=4.
